freq_gate_counter: RTL

- Upstream stage of the seven-segment display path: measures the frequency of an asynchronous external square wave and produces a saturated 16-bit binary count in Hz.
- The count feeds the binary-to-BCD converter and then the 4-digit multiplexed display.
- Method: synchronise the input, detect rising edges, count them over a fixed gate window, then latch the result once per window.

---
 rtl/freq_pkg.sv | 20 ++
 rtl/edge_sync.sv | 30 +++
 rtl/freq_gate_counter.sv | 90 +++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency measurement and seven-segment display path.
package freq_pkg;

    localparam int FREQ_W              = 16;
    localparam int MAX_COUNT           = 9999;
    localparam int DEFAULT_GATE_CYCLES = 100_000_000;
    localparam int DEFAULT_CW          = 27;

    typedef logic [FREQ_W-1:0] freq_t;

    // Two-state measurement FSM, encoded as plain constants for older tool flows.
    typedef logic [0:0] state_t;
    localparam state_t SETTLE  = 1'b0;
    localparam state_t MEASURE = 1'b1;

    function automatic freq_t saturate(input freq_t count, input freq_t ceiling);
        return (count > ceiling) ? ceiling : count;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input, followed by a rising-edge detector.
module edge_sync #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 is only a delayed copy used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= RESET_LEVEL;
            s2 <= RESET_LEVEL;
            s3 <= RESET_LEVEL;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronised rising edges of infreq over a fixed
// window and latches a saturated Hz value once per window.
module freq_gate_counter #(
    parameter int GATE_CYCLES = freq_pkg::DEFAULT_GATE_CYCLES,
    parameter int MAX_COUNT   = freq_pkg::MAX_COUNT,
    parameter int CW          = freq_pkg::DEFAULT_CW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        infreq,
    input  logic                        hold,
    output logic [freq_pkg::FREQ_W-1:0] freq,
    output logic                        freq_valid,
    output logic                        overrange
);

    import freq_pkg::*;

    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
    localparam freq_t         MAX_FREQ  = freq_t'(MAX_COUNT);
    localparam freq_t         SAT_COUNT = freq_t'(MAX_COUNT + 1);

    logic          rise;
    logic          tc;
    logic [CW-1:0] gate;
    freq_t         count;
    freq_t         count_next;
    state_t        state;

    edge_sync #(
        .RESET_LEVEL (1'b0)
    ) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (infreq),
        .rise     (rise)
    );

    assign tc = (gate == GATE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate <= '0;
        end else if (tc) begin
            gate <= '0;
        end else begin
            gate <= gate + CW'(1);
        end
    end

    // Counting stops one above MAX_COUNT so overrange stays detectable without wrapping.
    always_comb begin
        count_next = count;
        if (rise && (count < SAT_COUNT)) begin
            count_next = count + freq_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // count_next is latched so a rise in the tc cycle belongs to the closing window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SETTLE;
            freq       <= '0;
            freq_valid <= 1'b0;
            overrange  <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (tc) begin
                if (state == SETTLE) begin
                    state <= MEASURE;
                end else if (!hold) begin
                    freq       <= saturate(count_next, MAX_FREQ);
                    overrange  <= (count_next > MAX_FREQ);
                    freq_valid <= 1'b1;
                end
            end
        end
    end

endmodule
